writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports `clock` and `ctrl_reset_n`.
REQ-002 It SHALL have port `clock`, input, 1 bit: rising-edge system clock.
REQ-003 It SHALL have port `ctrl_reset_n`, input, 1 bit: async active-low reset.
REQ-004 It SHALL have port `pipe_valid`, input, 1 bit: pipeline W-stage has a register write this cycle.
REQ-005 It SHALL have port `pipe_rd`, input, 5 bits: pipeline destination register.
REQ-006 It SHALL have port `pipe_data`, input, 32 bits: pipeline write data.
REQ-007 It SHALL have port `md_valid`, input, 1 bit: multdiv result offered.
REQ-008 It SHALL have port `md_rd`, input, 5 bits: multdiv destination register.
REQ-009 It SHALL have port `md_data`, input, 32 bits: multdiv result.
REQ-010 It SHALL have port `md_ready`, output, 1 bit: arbiter accepts a multdiv result this cycle.
REQ-011 It SHALL have port `ctrl_writeEnable`, output, 1 bit: registered write enable to the regfile.
REQ-012 It SHALL have port `ctrl_writeReg`, output, 5 bits: registered write address.
REQ-013 It SHALL have port `data_writeReg`, output, 32 bits: registered write data.
REQ-014 It SHALL have port `pending_mask`, output, 32 bits: bit n set while a valid buffered multdiv result targets rN.

Function
REQ-015 A multdiv result SHALL be accepted at a rising edge iff md_valid && md_ready.
REQ-016 md_ready SHALL equal (entry count < 2), computed from current state only; a pop in the same cycle does not raise it.
REQ-017 Accepted results SHALL go into a 2-entry FIFO holding {valid, rd, data}, in arrival order.
REQ-018 An accepted result with md_rd == 0 SHALL be consumed and discarded: not stored, no write.
REQ-019 A pipeline write SHALL be eligible iff pipe_valid && pipe_rd != 0; pipe_rd == 0 produces no write.
REQ-020 Per-cycle grant priority: (1) eligible pipeline write, (2) FIFO head, (3) direct bypass of an md result accepted this cycle into an empty FIFO.
REQ-021 Bypass: with FIFO empty, no eligible pipe write, and an md result accepted, the result SHALL be written directly and not stored.
REQ-022 A granted write SHALL appear on ctrl_writeEnable/ctrl_writeReg/data_writeReg at the next rising edge (1-cycle latency), held exactly one cycle.
REQ-023 With no grant, ctrl_writeEnable SHALL be 0 at the next edge; ctrl_writeReg and data_writeReg SHALL hold their previous values.
REQ-024 Ordering: a granted pipeline write to rN SHALL clear the valid bit of every FIFO entry with rd == rN, and of an md result accepted the same cycle with md_rd == rN.
REQ-025 An invalid entry at the FIFO head SHALL be popped in one cycle and SHALL NOT produce a write.
REQ-026 This pop takes the FIFO-head grant slot.
REQ-027 pending_mask SHALL be the OR of the one-hot decodes of rd over valid FIFO entries, combinational from state.
REQ-028 pending_mask SHALL NOT include bypassed results.
REQ-029 With count == 2 and md_valid high, md_ready SHALL stay 0.
REQ-030 With count == 2 and md_valid high, the result SHALL NOT be accepted, and no state SHALL change apart from a normal pop.
REQ-031 A simultaneous push and pop at count == 1 SHALL leave count at 1, with the new entry becoming the head after the old head leaves.

Reset
REQ-032 While ctrl_reset_n == 0, ctrl_writeEnable, ctrl_writeReg, data_writeReg and pending_mask SHALL be 0.
REQ-033 While ctrl_reset_n == 0, the FIFO SHALL be empty (count 0, valid bits 0) and md_ready SHALL be forced to 0.
REQ-034 Assertion of ctrl_reset_n mid-operation SHALL discard all buffered results immediately, without waiting for a clock edge.
REQ-035 No write SHALL be issued for a discarded result.
REQ-036 After ctrl_reset_n deasserts, md_ready SHALL be 1 and the first write SHALL be possible one edge after the first grant.

Verification
REQ-037 Pipe-only test: pipe_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> next edge writeEnable=1, writeReg=5, data=0xDEADBEEF; writeEnable=0 on the edge after.
REQ-038 Bypass test: FIFO empty, pipe_valid=0, md rd=7, data=42 -> md_ready=1, write rd=7/42 one edge later, pending_mask stays 0.
REQ-039 Buffering test: pipe writes rd=1 for 3 consecutive cycles while md offers rd=9 then rd=10 -> both buffered.
REQ-040 Buffering test (cont.): pending_mask=0x00000600 and md_ready=0; a third md offer is not accepted.
REQ-041 Buffering test (cont.): after the pipe goes idle, writes occur as rd=9 then rd=10 on consecutive edges.
REQ-042 Invalidation test: FIFO holds rd=3, then pipe writes rd=3 data=0x11 -> pending_mask bit 3 clears; only the 0x11 write to r3 occurs; the stale entry is popped with no write.
REQ-043 Zero-register test: pipe rd=0 and md rd=0 together -> no write is issued and nothing is stored.
REQ-044 Reset test: with 2 entries buffered, pull ctrl_reset_n low mid-cycle -> all outputs 0 immediately; after release md_ready=1 and no stale writes occur.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges pipeline W-stage writes and multdiv results onto
// the single regfile write port. Pipeline writes always win; multdiv results
// that cannot be written immediately wait in a 2-entry FIFO. A pipeline write
// to a register kills any older buffered multdiv result for that register,
// so a stale result can never overwrite newer data.
module writeback_arbiter (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic [31:0] pending_mask
);

    // FIFO storage: slot 0 is always the head, slot 1 the tail.
    logic [1:0]  ent_v_q,    ent_v_d;
    logic [4:0]  ent_rd_q   [2];
    logic [4:0]  ent_rd_d   [2];
    logic [31:0] ent_data_q [2];
    logic [31:0] ent_data_d [2];
    logic [1:0]  cnt_q,      cnt_d;

    // Registered regfile write port.
    logic        we_q,    we_d;
    logic [4:0]  wreg_q,  wreg_d;
    logic [31:0] wdata_q, wdata_d;

    logic        pipe_elig;
    logic        md_acc;
    logic        md_real;
    logic        pop;
    logic        bypass;
    logic        push;
    logic        push_v;
    logic [1:0]  ent_v_kill;
    logic [1:0]  cnt_pop;

    // Ready depends on occupancy only; a pop in the same cycle does not help.
    assign md_ready = ctrl_reset_n && (cnt_q != 2'd2);

    // Registers with a live buffered result, used by hazard logic upstream.
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < 2; i++) begin
            if (ent_v_q[i]) begin
                pending_mask = pending_mask | (32'd1 << ent_rd_q[i]);
            end
        end
    end

    // Grant selection, ordering kills and next FIFO contents.
    always_comb begin
        pipe_elig = pipe_valid && (pipe_rd != 5'd0);
        md_acc    = md_valid && md_ready;
        // r0 results are accepted but simply dropped.
        md_real   = md_acc && (md_rd != 5'd0);

        // A granted pipe write supersedes older buffered results for its rd.
        for (int i = 0; i < 2; i++) begin
            ent_v_kill[i] = ent_v_q[i] && !(pipe_elig && (ent_rd_q[i] == pipe_rd));
        end
        push_v = !(pipe_elig && (md_rd == pipe_rd));

        pop    = !pipe_elig && (cnt_q != 2'd0);
        bypass = !pipe_elig && (cnt_q == 2'd0) && md_real;
        push   = md_real && !bypass;

        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (pipe_elig) begin
            we_d    = 1'b1;
            wreg_d  = pipe_rd;
            wdata_d = pipe_data;
        end else if (pop) begin
            // An invalidated head still consumes the slot but writes nothing.
            if (ent_v_q[0]) begin
                we_d    = 1'b1;
                wreg_d  = ent_rd_q[0];
                wdata_d = ent_data_q[0];
            end
        end else if (bypass) begin
            we_d    = 1'b1;
            wreg_d  = md_rd;
            wdata_d = md_data;
        end

        ent_v_d    = ent_v_kill;
        ent_rd_d   = ent_rd_q;
        ent_data_d = ent_data_q;
        cnt_pop    = cnt_q;
        if (pop) begin
            ent_v_d[0]    = ent_v_kill[1];
            ent_rd_d[0]   = ent_rd_q[1];
            ent_data_d[0] = ent_data_q[1];
            ent_v_d[1]    = 1'b0;
            cnt_pop       = cnt_q - 2'd1;
        end
        if (push) begin
            ent_v_d[cnt_pop[0]]    = push_v;
            ent_rd_d[cnt_pop[0]]   = md_rd;
            ent_data_d[cnt_pop[0]] = md_data;
        end
        cnt_d = cnt_pop + {1'b0, push};
    end

    // State and output registers; reset empties the FIFO without a clock.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            ent_v_q <= 2'b00;
            cnt_q   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                ent_rd_q[i]   <= 5'd0;
                ent_data_q[i] <= 32'd0;
            end
            we_q    <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            ent_v_q <= ent_v_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 2; i++) begin
                ent_rd_q[i]   <= ent_rd_d[i];
                ent_data_q[i] <= ent_data_d[i];
            end
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_writeback_arbiter;

    logic        clock = 1'b0;
    logic        ctrl_reset_n = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = 5'd0;
    logic [31:0] pipe_data = 32'd0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_rd = 5'd0;
    logic [31:0] md_data = 32'd0;
    logic        md_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pending_mask;

    writeback_arbiter dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .pipe_valid       (pipe_valid),
        .pipe_rd          (pipe_rd),
        .pipe_data        (pipe_data),
        .md_valid         (md_valid),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pending_mask     (pending_mask)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic        m_we   = 1'b0;
    logic [4:0]  m_reg  = 5'd0;
    logic [31:0] m_data = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = 32'd0;
        foreach (mq[i]) if (mq[i].v) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    // One clock of traffic: drive, check combinational outputs, advance the
    // model, then check the registered write port after the edge.
    task automatic cycle(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        bit   elig, acc, byp;
        ent_t h;
        @(negedge clock);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        md_valid = mv;   md_rd = mrd;   md_data = md;
        #1;
        chk("md_ready", {31'd0, md_ready}, {31'd0, (mq.size() < 2)});
        chk("pending_mask", pending_mask, model_mask());

        elig = pv && (prd != 5'd0);
        acc  = mv && (mq.size() < 2);
        byp  = 1'b0;
        if (elig) foreach (mq[i]) if (mq[i].rd == prd) mq[i].v = 1'b0;
        m_we = 1'b0;
        if (elig) begin
            m_we = 1'b1; m_reg = prd; m_data = pd;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            if (h.v) begin
                m_we = 1'b1; m_reg = h.rd; m_data = h.d;
            end
        end else if (acc && mrd != 5'd0) begin
            byp = 1'b1;
            m_we = 1'b1; m_reg = mrd; m_data = md;
        end
        if (acc && mrd != 5'd0 && !byp) begin
            h.v = !(elig && mrd == prd);
            h.rd = mrd;
            h.d = md;
            mq.push_back(h);
        end

        @(posedge clock);
        #1;
        chk("writeEnable", {31'd0, ctrl_writeEnable}, {31'd0, m_we});
        chk("writeReg", {27'd0, ctrl_writeReg}, {27'd0, m_reg});
        chk("writeData", data_writeReg, m_data);
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // Assert reset between edges and confirm everything clears without a clock.
    task automatic reset_mid();
        @(negedge clock);
        pipe_valid = 1'b0; md_valid = 1'b0;
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("rst_reg", {27'd0, ctrl_writeReg}, 32'd0);
        chk("rst_data", data_writeReg, 32'd0);
        chk("rst_mask", pending_mask, 32'd0);
        chk("rst_ready", {31'd0, md_ready}, 32'd0);
        mq.delete();
        m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0;
        @(posedge clock);
        #1;
        chk("rst_hold_we", {31'd0, ctrl_writeEnable}, 32'd0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, md_ready}, 32'd1);
    endtask

    initial begin
        #3;
        chk("init_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("init_reg", {27'd0, ctrl_writeReg}, 32'd0);
        chk("init_data", data_writeReg, 32'd0);
        chk("init_mask", pending_mask, 32'd0);
        chk("init_ready", {31'd0, md_ready}, 32'd0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        #1;
        chk("rel_ready", {31'd0, md_ready}, 32'd1);

        // Pipe-only write, then idle.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("pipe_we", {31'd0, ctrl_writeEnable}, 32'd1);
        chk("pipe_data", data_writeReg, 32'hDEADBEEF);
        idle();

        // Bypass into empty FIFO.
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd42);
        chk("byp_reg", {27'd0, ctrl_writeReg}, 32'd7);
        chk("byp_mask", pending_mask, 32'd0);

        // Buffering behind pipe writes, third offer refused.
        cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd9,  32'h900);
        cycle(1'b1, 5'd1, 32'hA2, 1'b1, 5'd10, 32'hA00);
        chk("buf_mask", pending_mask, 32'h0000_0600);
        chk("buf_ready", {31'd0, md_ready}, 32'd0);
        cycle(1'b1, 5'd1, 32'hA3, 1'b1, 5'd11, 32'hB00);
        idle();
        chk("drain1_reg", {27'd0, ctrl_writeReg}, 32'd9);
        idle();
        chk("drain2_reg", {27'd0, ctrl_writeReg}, 32'd10);
        idle();

        // Invalidation of a buffered result by a newer pipe write.
        cycle(1'b1, 5'd1, 32'hB1, 1'b1, 5'd3, 32'h77);
        chk("inv_mask_before", pending_mask, 32'h8);
        cycle(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0);
        chk("inv_mask_after", pending_mask, 32'd0);
        idle();
        chk("inv_nowrite", {31'd0, ctrl_writeEnable}, 32'd0);
        idle();

        // r0 from both sources.
        cycle(1'b1, 5'd0, 32'h5, 1'b1, 5'd0, 32'h6);
        chk("zero_we", {31'd0, ctrl_writeEnable}, 32'd0);
        idle();

        // Reset with two entries buffered.
        cycle(1'b1, 5'd1, 32'hC1, 1'b1, 5'd4, 32'h44);
        cycle(1'b1, 5'd1, 32'hC2, 1'b1, 5'd6, 32'h66);
        chk("rst_pre_mask", pending_mask, 32'h50);
        reset_mid();
        idle();
        idle();

        // Random traffic on a small register range to provoke collisions.
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                reset_mid();
            end else begin
                cycle($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
            end
        end
        for (int n = 0; n < 4; n++) idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
